// File: rtl/bpu_bht_btb_pkg.sv
// Shared types and counter helpers for the branch prediction unit.
// Counter helpers work on a 4-bit container so one set of functions covers CNT_W 1..4.
package bpu_bht_btb_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_BR   = 2'b01,
        KIND_JAL  = 2'b10,
        KIND_JALR = 2'b11
    } upd_kind_e;

    localparam int CNT_W_MAX = 4;

    function automatic logic [3:0] ctr_wnt(input int cnt_w);
        return (4'd1 << (cnt_w - 1)) - 4'd1;
    endfunction

    function automatic logic [3:0] ctr_wt(input int cnt_w);
        return 4'd1 << (cnt_w - 1);
    endfunction

    function automatic logic [3:0] ctr_max(input int cnt_w);
        logic [4:0] full;
        full = (5'd1 << cnt_w) - 5'd1;
        return full[3:0];
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c, input int cnt_w);
        return (c == ctr_max(cnt_w)) ? c : c + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] c);
        return (c == 4'd0) ? c : c - 4'd1;
    endfunction

endpackage

// File: rtl/bpu_bht_btb_if.sv
// Fetch-side lookup and ID-side update bundle between the core and the predictor.
interface bpu_bht_btb_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_if;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_next_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [1:0]      upd_kind;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict;
    logic            inv_all;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispred_cnt;

    modport master (
        output pc_if, upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inv_all,
        input  pred_hit, pred_taken, pred_next_pc, mispredict, branch_cnt, mispred_cnt
    );

    modport slave (
        input  pc_if, upd_valid, upd_pc, upd_kind, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, inv_all,
        output pred_hit, pred_taken, pred_next_pc, mispredict, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/bpu_bht_btb_table.sv
// Valid/tag/counter/target storage: async lookup and update read ports, one write port.
// Tags and targets carry no reset; valid gates every use of them.
module bpu_table
    import bpu_bht_btb_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv_all,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_valid,
    output logic [TAG_W-1:0] lk_tag,
    output logic [CNT_W-1:0] lk_ctr,
    output logic [XLEN-1:0]  lk_target,
    input  logic [IDX_W-1:0] up_idx,
    output logic             up_valid,
    output logic [TAG_W-1:0] up_tag,
    output logic [CNT_W-1:0] up_ctr,
    output logic [XLEN-1:0]  up_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [CNT_W-1:0] wr_ctr,
    input  logic [XLEN-1:0]  wr_target
);
    localparam logic [3:0]       WNT_EXT = ctr_wnt(CNT_W);
    localparam logic [CNT_W-1:0] WNT     = WNT_EXT[CNT_W-1:0];

    logic [ENTRIES-1:0] valid_q;
    logic [CNT_W-1:0]   ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    assign lk_valid  = valid_q[lk_idx];
    assign lk_tag    = tag_q[lk_idx];
    assign lk_ctr    = ctr_q[lk_idx];
    assign lk_target = target_q[lk_idx];

    assign up_valid  = valid_q[up_idx];
    assign up_tag    = tag_q[up_idx];
    assign up_ctr    = ctr_q[up_idx];
    assign up_target = target_q[up_idx];

    // inv_all wins over a same-cycle write so the table always ends empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            ctr_q[wr_idx]   <= wr_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/bpu_bht_btb.sv
// Branch prediction unit: zero-latency BHT/BTB lookup at IF, training and
// misprediction detection from ID, plus branch/mispredict event counters.
module bpu_bht_btb
    import bpu_bht_btb_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int XLEN    = 32
) (
    input logic          clk,
    input logic          rst,
    bpu_bht_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [3:0]       WT_EXT  = ctr_wt(CNT_W);
    localparam logic [3:0]       MAX_EXT = ctr_max(CNT_W);
    localparam logic [CNT_W-1:0] CTR_WT  = WT_EXT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CTR_MAX = MAX_EXT[CNT_W-1:0];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag_pc, up_tag_pc;
    logic             lk_valid, up_valid;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic [CNT_W-1:0] lk_ctr, up_ctr;
    logic [XLEN-1:0]  lk_target, up_target;

    logic             wr_en, wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [CNT_W-1:0] wr_ctr;
    logic [XLEN-1:0]  wr_target;

    logic             up_hit;
    logic [XLEN-1:0]  upd_seq, act_pc;
    logic [3:0]       ctr_ext, ctr_inc, ctr_dec;

    assign lk_idx    = bus.pc_if[IDX_W+1:2];
    assign lk_tag_pc = bus.pc_if[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx    = bus.upd_pc[IDX_W+1:2];
    assign up_tag_pc = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    bpu_table #(
        .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W), .XLEN(XLEN)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .inv_all  (bus.inv_all),
        .lk_idx   (lk_idx),
        .lk_valid (lk_valid),
        .lk_tag   (lk_tag),
        .lk_ctr   (lk_ctr),
        .lk_target(lk_target),
        .up_idx   (up_idx),
        .up_valid (up_valid),
        .up_tag   (up_tag),
        .up_ctr   (up_ctr),
        .up_target(up_target),
        .wr_en    (wr_en),
        .wr_idx   (up_idx),
        .wr_valid (wr_valid),
        .wr_tag   (wr_tag),
        .wr_ctr   (wr_ctr),
        .wr_target(wr_target)
    );

    // Logical && keeps the outputs clean while unwritten tags/targets are still X
    assign bus.pred_hit     = lk_valid && (lk_tag == lk_tag_pc);
    assign bus.pred_taken   = bus.pred_hit && lk_ctr[CNT_W-1];
    assign bus.pred_next_pc = bus.pred_taken ? lk_target : bus.pc_if + XLEN'(4);

    assign upd_seq = bus.upd_pc + XLEN'(4);
    assign act_pc  = (bus.upd_kind != KIND_NONE && bus.upd_taken) ? bus.upd_target : upd_seq;
    assign bus.mispredict = bus.upd_valid &&
        (bus.upd_pred_taken ? (bus.upd_pred_target != act_pc) : (act_pc != upd_seq));

    assign up_hit = up_valid && (up_tag == up_tag_pc);

    always_comb begin
        ctr_ext = '0;
        ctr_ext[CNT_W-1:0] = up_ctr;
        ctr_inc = sat_inc(ctr_ext, CNT_W);
        ctr_dec = sat_dec(ctr_ext);
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = up_valid;
        wr_tag    = up_tag;
        wr_ctr    = up_ctr;
        wr_target = up_target;
        if (bus.upd_valid) begin
            unique case (bus.upd_kind)
                KIND_BR: begin
                    if (up_hit) begin
                        wr_en  = 1'b1;
                        wr_ctr = bus.upd_taken ? ctr_inc[CNT_W-1:0] : ctr_dec[CNT_W-1:0];
                        if (bus.upd_taken) wr_target = bus.upd_target;
                    end else if (bus.upd_taken) begin
                        wr_en     = 1'b1;
                        wr_valid  = 1'b1;
                        wr_tag    = up_tag_pc;
                        wr_ctr    = CTR_WT;
                        wr_target = bus.upd_target;
                    end
                end
                KIND_JAL: begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tag    = up_tag_pc;
                    wr_ctr    = CTR_MAX;
                    wr_target = bus.upd_target;
                end
                // JALR targets are data-dependent; kind NONE hits are aliases or stale
                default: begin
                    if (up_hit) begin
                        wr_en    = 1'b1;
                        wr_valid = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.branch_cnt  <= '0;
            bus.mispred_cnt <= '0;
        end else begin
            if (bus.upd_valid && bus.upd_kind != KIND_NONE) bus.branch_cnt <= bus.branch_cnt + 32'd1;
            if (bus.mispredict) bus.mispred_cnt <= bus.mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_bpu_bht_btb.sv
// Directed scoreboard bench for bpu_bht_btb (ENTRIES=64, TAG_W=8, CNT_W=2).
module tb_bpu_bht_btb;
    import bpu_bht_btb_pkg::*;

    logic clk;
    logic rst;

    bpu_bht_btb_if #(.XLEN(32)) bus();

    bpu_bht_btb #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    task automatic expect_v(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: got %h with no expectation queued", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: got %h want %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic expect_pred(input string n, input logic hit, input logic tk, input logic [31:0] nxt);
        expect_v({n, "_hit"}, {31'd0, hit});
        expect_v({n, "_taken"}, {31'd0, tk});
        expect_v({n, "_next"}, nxt);
    endtask

    task automatic check_pred();
        check_v({31'd0, bus.pred_hit});
        check_v({31'd0, bus.pred_taken});
        check_v(bus.pred_next_pc);
    endtask

    task automatic expect_cnt(input string n, input logic [31:0] b, input logic [31:0] m);
        expect_v({n, "_branch_cnt"}, b);
        expect_v({n, "_mispred_cnt"}, m);
    endtask

    task automatic check_cnt();
        check_v(bus.branch_cnt);
        check_v(bus.mispred_cnt);
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic [1:0] kind, input logic tk,
                             input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_kind        = kind;
        bus.upd_taken       = tk;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptk;
        bus.upd_pred_target = ptgt;
    endtask

    task automatic idle_upd();
        bus.upd_valid      = 1'b0;
        bus.upd_kind       = KIND_NONE;
        bus.upd_taken      = 1'b0;
        bus.upd_pred_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.pc_if   = 32'h40;
        bus.inv_all = 1'b0;
        bus.upd_pc  = '0;
        bus.upd_target      = '0;
        bus.upd_pred_target = '0;
        idle_upd();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // reset state
        expect_pred("rst", 1'b0, 1'b0, 32'h44);
        expect_cnt("rst", 32'd0, 32'd0);
        check_pred();
        check_cnt();

        // first taken branch allocates; no bypass in the same cycle
        drive_upd(32'h40, KIND_BR, 1'b1, 32'h10, 1'b0, 32'h44);
        expect_v("alloc_mispredict", 32'd1);
        expect_v("alloc_no_bypass_hit", 32'd0);
        #1;
        check_v({31'd0, bus.mispredict});
        check_v({31'd0, bus.pred_hit});
        tick();
        idle_upd();
        expect_pred("alloc", 1'b1, 1'b1, 32'h10);
        expect_cnt("alloc", 32'd1, 32'd1);
        #1;
        check_pred();
        check_cnt();

        // three more taken: correct predictions, counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            drive_upd(32'h40, KIND_BR, 1'b1, 32'h10, 1'b1, 32'h10);
            expect_v("taken_ok_mispredict", 32'd0);
            #1;
            check_v({31'd0, bus.mispredict});
            tick();
        end
        idle_upd();
        expect_cnt("sat", 32'd4, 32'd1);
        #1;
        check_cnt();

        // not-taken from saturated 3 -> 2 still predicts taken
        drive_upd(32'h40, KIND_BR, 1'b0, 32'h10, 1'b1, 32'h10);
        expect_v("nt1_mispredict", 32'd1);
        #1;
        check_v({31'd0, bus.mispredict});
        tick();
        idle_upd();
        expect_pred("nt1", 1'b1, 1'b1, 32'h10);
        #1;
        check_pred();

        drive_upd(32'h40, KIND_BR, 1'b0, 32'h10, 1'b1, 32'h10);
        tick();
        idle_upd();
        expect_pred("nt2", 1'b1, 1'b0, 32'h44);
        expect_cnt("nt2", 32'd6, 32'd3);
        #1;
        check_pred();
        check_cnt();

        // not-taken at a missing PC must not allocate
        drive_upd(32'h80, KIND_BR, 1'b0, 32'h90, 1'b0, 32'h84);
        expect_v("miss_nt_mispredict", 32'd0);
        #1;
        check_v({31'd0, bus.mispredict});
        tick();
        idle_upd();
        bus.pc_if = 32'h80;
        expect_pred("miss_nt", 1'b0, 1'b0, 32'h84);
        expect_cnt("miss_nt", 32'd7, 32'd3);
        #1;
        check_pred();
        check_cnt();

        // aliasing: same index, tag 1
        bus.pc_if = 32'h140;
        expect_pred("alias", 1'b0, 1'b0, 32'h144);
        #1;
        check_pred();
        drive_upd(32'h140, KIND_JAL, 1'b1, 32'h200, 1'b0, 32'h144);
        expect_v("jal_mispredict", 32'd1);
        #1;
        check_v({31'd0, bus.mispredict});
        tick();
        idle_upd();
        expect_pred("jal", 1'b1, 1'b1, 32'h200);
        expect_cnt("jal", 32'd8, 32'd4);
        #1;
        check_pred();
        check_cnt();
        bus.pc_if = 32'h40;
        expect_v("jal_evicted_old_hit", 32'd0);
        #1;
        check_v({31'd0, bus.pred_hit});

        // kind NONE hitting an entry invalidates it
        drive_upd(32'h140, KIND_NONE, 1'b0, 32'h0, 1'b0, 32'h144);
        expect_v("none_mispredict", 32'd0);
        #1;
        check_v({31'd0, bus.mispredict});
        tick();
        idle_upd();
        bus.pc_if = 32'h140;
        expect_pred("none_inval", 1'b0, 1'b0, 32'h144);
        expect_cnt("none_inval", 32'd8, 32'd4);
        #1;
        check_pred();
        check_cnt();

        // same-cycle update and lookup: old value now, new value next cycle
        drive_upd(32'h40, KIND_BR, 1'b1, 32'h10, 1'b0, 32'h44);
        tick();
        idle_upd();
        bus.pc_if = 32'h40;
        expect_v("realloc_next", 32'h10);
        #1;
        check_v(bus.pred_next_pc);
        drive_upd(32'h40, KIND_JAL, 1'b1, 32'h300, 1'b1, 32'h300);
        expect_v("same_cycle_mispredict", 32'd0);
        expect_v("same_cycle_old_next", 32'h10);
        #1;
        check_v({31'd0, bus.mispredict});
        check_v(bus.pred_next_pc);
        tick();
        idle_upd();
        expect_v("same_cycle_new_next", 32'h300);
        expect_cnt("same_cycle", 32'd10, 32'd5);
        #1;
        check_v(bus.pred_next_pc);
        check_cnt();

        // inv_all beats a simultaneous allocate; counters survive
        bus.inv_all = 1'b1;
        drive_upd(32'h80, KIND_BR, 1'b1, 32'h500, 1'b0, 32'h84);
        expect_v("inv_mispredict", 32'd1);
        #1;
        check_v({31'd0, bus.mispredict});
        tick();
        bus.inv_all = 1'b0;
        idle_upd();
        expect_pred("inv_40", 1'b0, 1'b0, 32'h44);
        #1;
        check_pred();
        bus.pc_if = 32'h80;
        expect_pred("inv_80", 1'b0, 1'b0, 32'h84);
        expect_cnt("inv", 32'd11, 32'd6);
        #1;
        check_pred();
        check_cnt();

        // async reset between edges discards the pending update
        drive_upd(32'h40, KIND_JAL, 1'b1, 32'h700, 1'b1, 32'h700);
        tick();
        idle_upd();
        bus.pc_if = 32'h40;
        expect_pred("pre_rst", 1'b1, 1'b1, 32'h700);
        expect_cnt("pre_rst", 32'd12, 32'd6);
        #1;
        check_pred();
        check_cnt();
        drive_upd(32'h80, KIND_JAL, 1'b1, 32'h600, 1'b0, 32'h84);
        #2;
        rst = 1'b1;
        expect_pred("async_rst", 1'b0, 1'b0, 32'h44);
        expect_cnt("async_rst", 32'd0, 32'd0);
        #1;
        check_pred();
        check_cnt();
        tick();
        rst = 1'b0;
        idle_upd();
        bus.pc_if = 32'h80;
        expect_pred("post_rst", 1'b0, 1'b0, 32'h84);
        expect_cnt("post_rst", 32'd0, 32'd0);
        #1;
        check_pred();
        check_cnt();

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_leftover: got %0d unchecked want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
